// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_queue - single-outstanding instruction fetcher feeding a DEPTH-entry
// decode queue; define IFQ_BYPASS_EN to forward a response to an empty queue's
// output in the same cycle.  Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  FULL       = CW'(DEPTH);
  localparam logic [6:0]     OPC_SYSTEM = 7'b1110011;

  logic [31:0]   pc_q, pc_d;
  logic          outst_q, outst_d;
  logic          discard_q, discard_d;
  logic          stop_q, stop_d;
  logic          halted_q, halted_d;
  logic          started_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic        w_redir;
  logic        w_rsp;
  logic        w_rsp_ok;
  logic        w_empty;
  logic        w_bypass;
  logic        w_pop;
  logic        w_qpop;
  logic        w_push;
  logic        w_acc;
  logic [31:0] w_rsp_pc;
  logic        w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  assign w_redir  = redirect & ~halted_q;
  assign w_rsp    = imem_valid & outst_q;
  assign w_rsp_ok = w_rsp & ~discard_q & ~w_redir;
  assign w_empty  = (count_q == '0);
  // pc_q only moves on accept or redirect, and redirect discards the response,
  // so a kept response always belongs to pc_q - 4.
  assign w_rsp_pc = pc_q - 32'd4;

`ifdef IFQ_BYPASS_EN
  assign w_bypass    = w_rsp_ok & w_empty;
  assign fetch_valid = ~halted_q & (~w_empty | w_bypass);
  assign fetch_instr = w_bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
  assign fetch_pc    = w_bypass ? w_rsp_pc   : pc_mem_q[rd_ptr_q];
`else
  assign w_bypass    = 1'b0;
  assign fetch_valid = ~halted_q & ~w_empty;
  assign fetch_instr = instr_mem_q[rd_ptr_q];
  assign fetch_pc    = pc_mem_q[rd_ptr_q];
`endif

  assign w_pop  = fetch_valid & fetch_ready & ~w_redir;
  assign w_qpop = w_pop & ~w_bypass;
  assign w_push = w_rsp_ok & ~(w_bypass & fetch_ready);

  // A discarded response frees the request slot in the cycle it arrives.
  assign imem_req  = started_q & ~halted_q & ~stop_q & (count_q != FULL) &
                     (~outst_q | (imem_valid & discard_q));
  assign imem_addr = pc_q;
  assign w_acc     = imem_req & imem_ready;

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    stop_d    = stop_q | (w_rsp_ok & (imem_rdata[6:0] == OPC_SYSTEM));
    halted_d  = halted_q | (w_pop & (fetch_instr[6:0] == OPC_SYSTEM));
    rd_ptr_d  = rd_ptr_q + PW'(w_qpop);
    wr_ptr_d  = wr_ptr_q + PW'(w_push);
    count_d   = count_q + CW'(w_push) - CW'(w_qpop);

    if (w_rsp) begin
      outst_d   = 1'b0;
      discard_d = 1'b0;
    end
    if (w_acc) begin
      pc_d      = pc_q + 32'd4;
      outst_d   = 1'b1;
      discard_d = 1'b0;
    end

    if (w_redir) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      stop_d    = 1'b0;
      discard_d = outst_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      outst_q   <= 1'b0;
      discard_q <= 1'b0;
      stop_q    <= 1'b0;
      halted_q  <= 1'b0;
      started_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      stop_q    <= stop_d;
      halted_q  <= halted_d;
      started_q <= 1'b1;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      if (w_push) begin
        pc_mem_q[wr_ptr_q]    <= w_rsp_pc;
        instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

  assign halted = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// Directed bench for instr_fetch_queue: memory responder plus a scoreboard of
// expected {pc, instr} entries checked whenever the decoder side pops.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_pc   (fetch_pc),
    .fetch_ready(fetch_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb[$];
  logic        pending, discard, resp_en, exp_stop, exp_halted;
  logic [31:0] paddr, exp_pc, last_acc, last_pop_pc, ecall_addr;
  int          n_pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ecall_addr) return 32'h0000_0073;
    return {a[19:0], 12'h013};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample DUT, update reference model, advance the edge, drive response.
  task automatic tick();
    logic acc, rsp, redir, exp_fv, halt_next;
    logic [31:0] aaddr;
    #1;
    halt_next = 1'b0;
    redir     = redirect & ~exp_halted;
    rsp       = imem_valid & pending;
    acc       = imem_req & imem_ready;
    aaddr     = imem_addr;
    check("halted", halted, exp_halted);
    if (exp_stop || exp_halted) check("req_while_stopped", imem_req, 1'b0);
    exp_fv = ((sb.size() != 0) || (BYP && rsp && !discard && !redir)) && !exp_halted;
    check("fetch_valid", fetch_valid, exp_fv);
    if (acc) begin
      check("imem_addr", aaddr, exp_pc);
      last_acc = aaddr;
    end
    if (rsp) begin
      pending = 1'b0;
      if (!discard && !redir) begin
        sb.push_back({paddr, mem_word(paddr)});
        if (mem_word(paddr) == 32'h0000_0073) exp_stop = 1'b1;
      end
      discard = 1'b0;
    end
    if (fetch_valid && fetch_ready && !redir) begin
      if (sb.size() == 0) begin
        check("pop_nonempty", 32'd0, 32'd1);
      end else begin
        check("pop_pc", fetch_pc, sb[0][63:32]);
        check("pop_instr", fetch_instr, sb[0][31:0]);
        if (sb[0][6:0] == 7'b1110011) halt_next = 1'b1;
        last_pop_pc = sb[0][63:32];
        void'(sb.pop_front());
        n_pops++;
      end
    end
    if (acc) begin
      pending = 1'b1;
      paddr   = aaddr;
      exp_pc  = exp_pc + 32'd4;
      discard = 1'b0;
    end
    if (redir) begin
      sb.delete();
      exp_pc   = {redirect_pc[31:2], 2'b00};
      exp_stop = 1'b0;
      discard  = pending;
    end
    if (halt_next) exp_halted = 1'b1;
    @(posedge clk);
    #1;
    imem_valid = pending & resp_en;
    imem_rdata = imem_valid ? mem_word(paddr) : 32'h0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    fetch_ready = 1'b0;
    imem_ready  = 1'b1;
    imem_valid  = 1'b1;            // stray response during reset must be dropped
    imem_rdata  = 32'h0000_0073;
    sb.delete();
    pending    = 1'b0;
    discard    = 1'b0;
    resp_en    = 1'b1;
    exp_pc     = 32'h0;
    exp_stop   = 1'b0;
    exp_halted = 1'b0;
    #1;
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch_instr", fetch_instr, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_halted", halted, 1'b0);
    #2;
    reset      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    #1;
    check("req_before_first_edge", imem_req, 1'b0);
    check("empty_after_reset", fetch_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    ecall_addr = 32'hFFFF_FFF0;
    last_acc   = 32'hFFFF_FFFF;
    last_pop_pc = 32'hFFFF_FFFF;
    n_pops = 0;

    // Fill with decoder stalled; check response-to-valid latency and full stall.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = imem_valid;
    end
    check("first_resp_seen", found, 1'b1);
    #1;
    check("latency_same_cycle", fetch_valid, BYP);
    tick();
    check("latency_next_cycle", fetch_valid, 1'b1);
    check("head_pc_0", fetch_pc, 32'h0);
    repeat (12) tick();
    check("full_no_req", imem_req, 1'b0);
    check("queued_entries", 32'(sb.size()), 32'd4);
    // Release: pops in order, fetching resumes at 0x10 (checked per accept).
    fetch_ready = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 80 && n_pops < 12; i++) tick();
    check("stream_pops", 32'(n_pops), 32'd12);

    // Redirect while the request to 0x8 is outstanding.
    do_reset();
    fetch_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = (last_acc == 32'h8) && pending;
    end
    check("reached_0x8", found, 1'b1);
    resp_en    = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("flush_empty", fetch_valid, 1'b0);
    check("redirect_addr", imem_addr, 32'h100);
    resp_en    = 1'b1;
    imem_valid = pending;
    imem_rdata = mem_word(paddr);
    n_pops = 0;
    for (int i = 0; i < 20 && n_pops < 1; i++) tick();
    check("first_pc_after_redirect", last_pop_pc, 32'h100);
    repeat (6) tick();

    // ECALL at 0xC stops fetch and halts after it is consumed; redirect ignored.
    do_reset();
    ecall_addr  = 32'hC;
    fetch_ready = 1'b1;
    repeat (20) tick();
    check("halted_after_ecall", halted, 1'b1);
    check("no_fetch_past_ecall", last_acc, 32'hC);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    check("redirect_ignored_addr", imem_addr, 32'h10);
    check("redirect_ignored_req", imem_req, 1'b0);
    ecall_addr = 32'hFFFF_FFF0;

    // Reset in the middle of traffic with three entries queued.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = (sb.size() == 3);
    end
    check("three_queued", found, 1'b1);
    #2;
    do_reset();
    fetch_ready = 1'b1;
    last_acc = 32'hFFFF_FFFF;
    n_pops = 0;
    repeat (12) tick();
    check("post_reset_pops", 32'(n_pops != 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port imem_req, output, 1, fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-007 SHALL have port imem_ready, input, 1, memory accepts request when high with imem_req.
REQ-008 SHALL have port imem_valid, input, 1, response data valid.
REQ-009 SHALL have port imem_rdata, input, 32, response instruction word.
REQ-010 SHALL have port fetch_valid, output, 1, head entry valid toward decoder.
REQ-011 SHALL have port fetch_instr, output, 32, head instruction.
REQ-012 SHALL have port fetch_pc, output, 32, head instruction PC.
REQ-013 SHALL have port fetch_ready, input, 1, decoder consumes head when high with fetch_valid.
REQ-014 SHALL have port redirect, input, 1, PC redirect (taken branch, JAL, JALR).
REQ-015 SHALL have port redirect_pc, input, 32, redirect target.
REQ-016 SHALL have port halted, output, 1, ECALL consumed; fetch stopped.

Function
REQ-017 SHALL keep at most one request outstanding; issue (imem_req=1) only when not halted, not stopped, no outstanding request, and occupancy < DEPTH.
REQ-018 SHALL hold imem_addr = fetch PC stable while imem_req is high and imem_ready low.
REQ-019 SHALL advance fetch PC by 4 on each accepted request (imem_req & imem_ready); wrap modulo 2^32.
REQ-020 SHALL push {PC, imem_rdata} on imem_valid with outstanding request, unless marked discard.
REQ-021 SHALL pop head on fetch_valid & fetch_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 SHALL, without bypass, present a pushed entry on fetch_valid no earlier than the next cycle (1-cycle latency).
REQ-023 SHALL set a stop flag when a pushed instruction has opcode[6:0] = 7'b1110011 (ECALL); no further requests issued.
REQ-024 SHALL assert halted the cycle after the ECALL entry is popped; halted sticky until reset; fetch_valid 0 while halted.
REQ-025 SHALL on redirect: flush queue, set fetch PC = redirect_pc, clear stop flag, mark any outstanding request discard; takes precedence over same-cycle push/pop/accept.
REQ-026 SHALL drop a discarded response on arrival and clear outstanding; new request may issue the same cycle the discarded response arrives.
REQ-027 SHALL ignore redirect while halted.
REQ-028 SHALL ignore redirect_pc[1:0] (force 2'b00).

Reset
REQ-029 SHALL on reset: fetch PC = RESET_PC, queue empty, outstanding = 0, discard = 0, stop = 0, halted = 0, imem_req = 0, fetch_valid = 0, fetch_instr = 0, fetch_pc = 0.
REQ-030 SHALL issue the first request no earlier than the first rising edge after reset deasserts.
REQ-031 SHALL discard any response arriving while reset is asserted.

Configuration
REQ-032 SHALL, with IFQ_BYPASS_EN defined, forward a non-discarded response directly to fetch_valid/fetch_instr/fetch_pc in the same cycle when queue empty; if fetch_ready is also high the entry SHALL NOT be pushed.
REQ-033 SHALL, without IFQ_BYPASS_EN, have no combinational path from imem_* to fetch_*.

Verification
REQ-034 Reset then imem_ready=1, 1-cycle responses, fetch_ready=1 -> fetch_pc 0x0,0x4,0x8... in order, instructions match memory.
REQ-035 fetch_ready=0 with DEPTH=4 -> exactly 4 entries queued, imem_req stays 0; release -> 4 pops in order, fetching resumes at 0x10.
REQ-036 Redirect to 0x100 while request to 0x8 outstanding -> 0x8 response dropped, next fetch_pc 0x100, queue empty after redirect.
REQ-037 ECALL (0x00000073) at 0xC -> no request to 0x10 issued; halted=1 cycle after pop at 0xC; later redirect ignored.
REQ-038 Reset asserted mid-transfer with 3 entries queued -> fetch_valid=0 immediately, next request address RESET_PC.
REQ-039 IFQ_BYPASS_EN defined, empty queue, response at cycle N -> fetch_valid=1 in cycle N; undefined -> fetch_valid=1 in cycle N+1.
